uart_spi_cmd_ctrl: RTL

Frame controller that sits between the UART receiver and the SPI master in the UART-to-SPI bridge. It consumes received bytes through the receiver's ready/clear handshake and parses framed commands (header, length, payload, optional checksum). It buffers the payload, then sequences the SPI master one byte at a time under a single chip-select window. It reports frame success or a coded error, and drops partial frames on an inter-byte timeout.

---
 rtl/uart_spi_bridge_pkg.sv | 26 ++
 rtl/cmd_timeout_timer.sv | 44 ++++
 rtl/uart_spi_cmd_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_spi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_bridge_pkg
// Brief    : Shared state encoding, frame header and error codes for the
//            UART-to-SPI command controller.
// Revision : 1.0
// ============================================================================
package uart_spi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT    = 3'd5
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_CHK = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module   : cmd_timeout_timer
// Brief    : Inter-byte timeout counter with clear/enable and a combinational
//            terminal-count pulse at TIMEOUT_CYC-1.
// Revision : 1.0
// ============================================================================
module cmd_timeout_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = en && (cnt_q == TC_VAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || tc) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_spi_cmd_ctrl
// Brief    : Parses A5/LEN/payload[/CHK] frames from the UART receiver and
//            replays the payload to the SPI master under one chip select.
//            Optional checksum byte enabled by UART_SPI_CMD_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module uart_spi_cmd_ctrl
    import uart_spi_bridge_pkg::*;
#(
    parameter int MAX_LEN     = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_rdy_clr,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    input  logic       spi_busy,
    input  logic       spi_done,
    output logic       spi_cs_n,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(MAX_LEN + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] len_q, len_d;
    logic [7:0]    buf_q [MAX_LEN];
    logic [7:0]    buf_d [MAX_LEN];
    logic          rx_rdy_clr_q, rx_rdy_clr_d;
    logic          spi_start_q, spi_start_d;
    logic [7:0]    spi_tx_q, spi_tx_d;
    logic          spi_cs_n_q, spi_cs_n_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
`ifdef UART_SPI_CMD_CHECKSUM_EN
    logic [7:0]    xor_q, xor_d;
`endif

    logic w_rx_state;
    logic w_accept;
    logic w_timed;
    logic w_tmo;
    logic w_last;

    assign w_rx_state = (state_q == ST_IDLE) || (state_q == ST_LEN) ||
                        (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // The clear pulse masks rx_rdy so a byte still flagged is never taken twice.
    assign w_accept   = rx_rdy && !rx_rdy_clr_q && w_rx_state;
    assign w_timed    = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) ||
                        (state_q == ST_CHK);
    assign w_last     = (idx_q == (len_q - IW'(1)));

    cmd_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_accept),
        .en  (w_timed),
        .tc  (w_tmo)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        buf_d        = buf_q;
        rx_rdy_clr_d = w_accept;
        spi_start_d  = 1'b0;
        spi_tx_d     = spi_tx_q;
        spi_cs_n_d   = spi_cs_n_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
`ifdef UART_SPI_CMD_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept && (rx_data == HDR_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d   = rx_data[IW-1:0];
                        idx_d   = '0;
                        state_d = ST_PAYLOAD;
`ifdef UART_SPI_CMD_CHECKSUM_EN
                        xor_d   = rx_data;
`endif
                    end
                end else if (w_tmo) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TMO;
                    state_d     = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    buf_d[idx_q] = rx_data;
`ifdef UART_SPI_CMD_CHECKSUM_EN
                    xor_d = xor_q ^ rx_data;
`endif
                    if (w_last) begin
                        idx_d = '0;
`ifdef UART_SPI_CMD_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d    = ST_SEND;
                        spi_cs_n_d = 1'b0;
`endif
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (w_tmo) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TMO;
                    state_d     = ST_IDLE;
                end
            end
            ST_CHK: begin
`ifdef UART_SPI_CMD_CHECKSUM_EN
                if (w_accept) begin
                    if (rx_data == xor_q) begin
                        state_d    = ST_SEND;
                        spi_cs_n_d = 1'b0;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = ST_IDLE;
                    end
                end else if (w_tmo) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TMO;
                    state_d     = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_SEND: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    spi_tx_d    = buf_q[idx_q];
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_done) begin
                    if (w_last) begin
                        spi_cs_n_d = 1'b1;
                        frame_ok_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
            rx_rdy_clr_q <= 1'b0;
            spi_start_q  <= 1'b0;
            spi_tx_q     <= '0;
            spi_cs_n_q   <= 1'b1;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
`ifdef UART_SPI_CMD_CHECKSUM_EN
            xor_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            buf_q        <= buf_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            spi_start_q  <= spi_start_d;
            spi_tx_q     <= spi_tx_d;
            spi_cs_n_q   <= spi_cs_n_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
`ifdef UART_SPI_CMD_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign spi_start  = spi_start_q;
    assign spi_tx     = spi_tx_q;
    assign spi_cs_n   = spi_cs_n_q;
    assign frame_ok   = frame_ok_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;

endmodule
`default_nettype wire
